// File: rtl/bnn_weight_streamer.sv
// Streams a shadow store of 8-bit weight bytes to a BNN core as low/high nibble
// pairs, one nibble per enabled cycle, under host start/abort control.
module bnn_weight_streamer #(
  parameter int NUM_NEURONS = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       start,
  input  logic       abort,
  output logic       load_en,
  output logic [3:0] weight_nib,
  output logic [3:0] neuron_idx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_NEURONS - 1);

  // Core power-on weights; bytes beyond the table default to zero.
  function automatic logic [7:0] default_byte(input logic [3:0] idx);
    logic [7:0] val;
    case (idx)
      4'd0:    val = 8'hA0;
      4'd1:    val = 8'h41;
      4'd2:    val = 8'h7A;
      4'd3:    val = 8'h18;
      4'd4:    val = 8'hED;
      4'd5:    val = 8'hB7;
      4'd6:    val = 8'h67;
      4'd7:    val = 8'h3A;
      4'd8:    val = 8'hF9;
      4'd9:    val = 8'h62;
      4'd10:   val = 8'hF7;
      4'd11:   val = 8'h0F;
      default: val = 8'h00;
    endcase
    return val;
  endfunction

  logic [7:0] r_shadow [NUM_NEURONS];
  state_t     r_state;
  logic [3:0] r_idx;
  logic       r_load;
  logic [3:0] r_nib;
  logic       r_busy;
  logic       r_done;

  state_t     w_state_nxt;
  logic [3:0] w_idx_nxt;
  logic       w_load_nxt;
  logic [3:0] w_nib_nxt;
  logic       w_busy_nxt;
  logic       w_done_nxt;
  logic [7:0] w_byte;
  logic       w_wr_ok;

  // The shadow store is locked for the whole transfer so streamed data is stable.
  assign w_wr_ok = ena & wr_en & ~r_busy & (wr_addr <= LAST_IDX);

  // Shadow store: defaults on reset, host writes only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        r_shadow[i] <= default_byte(4'(i));
      end
    end else if (w_wr_ok) begin
      r_shadow[wr_addr] <= wr_data;
    end
  end

  // State and index register; frozen while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= 4'd0;
    end else if (ena) begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next-state and next-index decode.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: begin
        w_idx_nxt = 4'd0;
        if (start && !abort) begin
          w_state_nxt = S_LO;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LO: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = 4'd0;
        end else begin
          w_state_nxt = S_HI;
        end
      end
      S_HI: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = 4'd0;
        end else if (r_idx == LAST_IDX) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_LO;
          w_idx_nxt   = r_idx + 4'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = 4'd0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = 4'd0;
      end
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up with it.
  always_comb begin
    w_load_nxt = 1'b0;
    w_nib_nxt  = 4'd0;
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    w_byte     = r_shadow[w_idx_nxt];
    case (w_state_nxt)
      S_LO: begin
        w_load_nxt = 1'b1;
        w_nib_nxt  = w_byte[3:0];
        w_busy_nxt = 1'b1;
      end
      S_HI: begin
        w_load_nxt = 1'b1;
        w_nib_nxt  = w_byte[7:4];
        w_busy_nxt = 1'b1;
      end
      S_DONE: begin
        w_busy_nxt = 1'b1;
        w_done_nxt = 1'b1;
      end
      default: begin
        w_load_nxt = 1'b0;
        w_nib_nxt  = 4'd0;
      end
    endcase
  end

  // Output registers; frozen while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load <= 1'b0;
      r_nib  <= 4'd0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (ena) begin
      r_load <= w_load_nxt;
      r_nib  <= w_nib_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign load_en    = r_load & ena;
  assign weight_nib = r_nib;
  assign neuron_idx = r_idx;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_bnn_weight_streamer.sv
// Directed bench for bnn_weight_streamer: nibble order, shadow writes,
// ena freeze, abort and reset behaviour against hand-computed byte tables.
module tb_bnn_weight_streamer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = 4'd0;
  logic [7:0] wr_data = 8'd0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       load_en;
  logic [3:0] weight_nib;
  logic [3:0] neuron_idx;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_b [12];

  bnn_weight_streamer #(.NUM_NEURONS(12)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .abort(abort), .load_en(load_en),
    .weight_nib(weight_nib), .neuron_idx(neuron_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_defaults();
    exp_b[0] = 8'hA0; exp_b[1] = 8'h41; exp_b[2]  = 8'h7A; exp_b[3]  = 8'h18;
    exp_b[4] = 8'hED; exp_b[5] = 8'hB7; exp_b[6]  = 8'h67; exp_b[7]  = 8'h3A;
    exp_b[8] = 8'hF9; exp_b[9] = 8'h62; exp_b[10] = 8'hF7; exp_b[11] = 8'h0F;
  endtask

  task automatic check_idle(input string nm);
    n_cmp++;
    if (load_en !== 1'b0 || weight_nib !== 4'd0 || neuron_idx !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL %s: load_en=%b nib=%h idx=%0d busy=%b done=%b, want 0 0 0 0 0",
               nm, load_en, weight_nib, neuron_idx, busy, done);
    end
  endtask

  // Full transfer against exp_b; optional ena gap, ignored restart, write hammering.
  task automatic run_stream(input string nm, input int gap_at, input int restart_at, input bit hammer);
    int highs;
    logic [3:0] exp_nib;
    logic [3:0] hold_nib;
    logic [3:0] hold_idx;
    highs = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    if (hammer) begin
      wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h55;
    end
    for (int k = 0; k < 24; k++) begin
      exp_nib = (k % 2 == 0) ? exp_b[k / 2][3:0] : exp_b[k / 2][7:4];
      n_cmp++;
      if (load_en !== 1'b1 || weight_nib !== exp_nib || neuron_idx !== 4'(k / 2) || busy !== 1'b1 || done !== 1'b0) begin
        n_err++;
        $display("FAIL %s nib%0d: load_en=%b nib=%h idx=%0d busy=%b done=%b, want 1 %h %0d 1 0",
                 nm, k, load_en, weight_nib, neuron_idx, busy, done, exp_nib, k / 2);
      end
      if (load_en === 1'b1) highs++;
      if (k == restart_at) start = 1'b1;
      if (k == gap_at) begin
        hold_nib = weight_nib;
        hold_idx = neuron_idx;
        ena = 1'b0;
        for (int j = 0; j < 3; j++) begin
          step();
          n_cmp++;
          if (load_en !== 1'b0 || weight_nib !== hold_nib || neuron_idx !== hold_idx || busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s gap%0d: load_en=%b nib=%h idx=%0d busy=%b, want 0 %h %0d 1",
                     nm, j, load_en, weight_nib, neuron_idx, busy, hold_nib, hold_idx);
          end
          if (load_en === 1'b1) highs++;
        end
        ena = 1'b1;
      end
      step();
      start = 1'b0;
    end
    wr_en = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || load_en !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s done_cycle: done=%b load_en=%b busy=%b, want 1 0 1", nm, done, load_en, busy);
    end
    step();
    check_idle({nm, " after_done"});
    n_cmp++;
    if (highs != 24) begin
      n_err++;
      $display("FAIL %s load_count: got %0d, want 24", nm, highs);
    end
  endtask

  task automatic write_byte(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    check_idle("reset_async");
    step();
    step();
    rst_n = 1'b1;
    step();
    check_idle("reset_release");
    set_defaults();
  endtask

  task automatic test_default_stream();
    run_stream("default", -1, -1, 1'b0);
  endtask

  task automatic test_write_byte();
    write_byte(4'd3, 8'h5C);
    exp_b[3] = 8'h5C;
    run_stream("write3", -1, -1, 1'b0);
  endtask

  task automatic test_bad_addr();
    write_byte(4'd12, 8'hFF);
    write_byte(4'd15, 8'hFF);
    run_stream("bad_addr", -1, -1, 1'b0);
  endtask

  task automatic test_write_busy();
    run_stream("write_busy", -1, -1, 1'b1);
    run_stream("after_busy_write", -1, 5, 1'b0);
  endtask

  task automatic test_ena_gap();
    run_stream("ena_gap", 9, -1, 1'b0);
  endtask

  task automatic test_start_abort_idle();
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check_idle("start_abort_idle");
    step();
    check_idle("start_abort_idle2");
  endtask

  task automatic test_abort();
    bit saw_done;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 11; k++) step();
    n_cmp++;
    if (load_en !== 1'b1 || neuron_idx !== 4'd5 || weight_nib !== exp_b[5][7:4]) begin
      n_err++;
      $display("FAIL abort_pre: load_en=%b idx=%0d nib=%h, want 1 5 %h", load_en, neuron_idx, weight_nib, exp_b[5][7:4]);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_idle("abort_idle");
    saw_done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
      step();
    end
    n_cmp++;
    if (saw_done !== 1'b0) begin
      n_err++;
      $display("FAIL abort_no_done: saw done/busy=%b, want 0", saw_done);
    end
    run_stream("after_abort", -1, -1, 1'b0);
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 6; k++) step();
    rst_n = 1'b0;
    #2;
    check_idle("reset_mid");
    step();
    rst_n = 1'b1;
    step();
    check_idle("reset_mid_release");
    set_defaults();
    run_stream("restored", -1, -1, 1'b0);
  endtask

  task automatic test_zero_weights();
    for (int i = 0; i < 12; i++) begin
      write_byte(4'(i), 8'h00);
      exp_b[i] = 8'h00;
    end
    run_stream("zeros", -1, -1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_default_stream();
    test_write_byte();
    test_bad_addr();
    test_write_busy();
    test_ena_gap();
    test_start_abort_idle();
    test_abort();
    test_reset_mid();
    test_zero_weights();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
